// File: rtl/mult_operand_stage_pkg.sv
// Shared multiplier definitions: operand/product widths and the skid-buffer
// state encoding used by the operand staging logic.
package mult_operand_stage_pkg;

    // Default signed operand width and resulting full product width.
    localparam int MULT_WIDTH = 16;
    localparam int PROD_WIDTH = 32;

    // Occupancy of the two-entry operand skid buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/mult_operand_stage.sv
// Operand register stage in front of the multiplier core.
// A two-entry skid buffer decouples upstream and downstream handshakes so
// that in_ready and out_valid are pure register decodes.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Once out_valid is high, the presented operands and flags stay
// stable until out_ready takes them. in_ready never depends on out_ready,
// and out_valid never depends on in_valid.
module mult_operand_stage
    import mult_operand_stage_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A_NUM,
    input  logic [WIDTH-1:0] B_NUM,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] A_REG,
    output logic [WIDTH-1:0] B_REG,
    output logic             A_NUM_sign,
    output logic             B_NUM_sign,
    output logic             zero_flag,
    output logic [15:0]      op_cnt,
    output logic [1:0]       dbg_state
);

    skid_state_e      r_state;

    // Output entry: always the oldest pair held by the stage.
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;
    logic             r_out_zero;

    // Skid entry: the younger pair, only meaningful in ST_FULL.
    logic [WIDTH-1:0] r_skid_a;
    logic [WIDTH-1:0] r_skid_b;
    logic             r_skid_zero;

    logic [15:0]      r_op_cnt;

    logic             w_accept;
    logic             w_handoff;
    logic             w_in_zero;

    // Ready/valid are decoded from the state register only.
    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);

    assign w_accept  = in_valid && in_ready;
    assign w_handoff = out_valid && out_ready;

    // Zero flag is computed from the incoming pair and stored alongside it.
    assign w_in_zero = (A_NUM == '0) || (B_NUM == '0);

    assign A_REG      = r_out_a;
    assign B_REG      = r_out_b;
    assign A_NUM_sign = r_out_a[WIDTH-1];
    assign B_NUM_sign = r_out_b[WIDTH-1];
    assign zero_flag  = r_out_zero;
    assign op_cnt     = r_op_cnt;
    assign dbg_state  = r_state;

    // Skid-buffer state machine, entry registers and accept counter.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_EMPTY;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_zero  <= 1'b0;
            r_skid_a    <= '0;
            r_skid_b    <= '0;
            r_skid_zero <= 1'b0;
            r_op_cnt    <= 16'd0;
        end else begin
            if (w_accept) begin
                r_op_cnt <= r_op_cnt + 16'd1;
            end

            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_out_a    <= A_NUM;
                        r_out_b    <= B_NUM;
                        r_out_zero <= w_in_zero;
                        r_state    <= ST_ONE;
                    end
                end

                ST_ONE: begin
                    if (w_accept && w_handoff) begin
                        // Old pair leaves, new pair takes the output slot.
                        r_out_a    <= A_NUM;
                        r_out_b    <= B_NUM;
                        r_out_zero <= w_in_zero;
                    end else if (w_accept) begin
                        // Output slot is stalled, park the new pair behind it.
                        r_skid_a    <= A_NUM;
                        r_skid_b    <= B_NUM;
                        r_skid_zero <= w_in_zero;
                        r_state     <= ST_FULL;
                    end else if (w_handoff) begin
                        r_state <= ST_EMPTY;
                    end
                end

                ST_FULL: begin
                    // in_ready is low here, so only a handoff can occur.
                    if (w_handoff) begin
                        r_out_a    <= r_skid_a;
                        r_out_b    <= r_skid_b;
                        r_out_zero <= r_skid_zero;
                        r_state    <= ST_ONE;
                    end
                end

                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_operand_stage.sv
// Bench for mult_operand_stage: directed scenarios plus random traffic,
// checked against a queue-based model of an in-order two-slot buffer.
module tb_mult_operand_stage;
  import mult_operand_stage_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_num;
  logic [W-1:0] b_num;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic         a_sign;
  logic         b_sign;
  logic         zero_flag;
  logic [15:0]  op_cnt;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  mult_operand_stage #(.WIDTH(W)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A_NUM      (a_num),
    .B_NUM      (b_num),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .A_REG      (a_reg),
    .B_REG      (b_reg),
    .A_NUM_sign (a_sign),
    .B_NUM_sign (b_sign),
    .zero_flag  (zero_flag),
    .op_cnt     (op_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  logic [15:0]    exp_cnt;
  int             n_cmp = 0;
  int             n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all outputs against the model's view of the buffer.
  task automatic check_outputs();
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    check("op_cnt", {16'd0, op_cnt}, {16'd0, exp_cnt});
    if (exp_q.size() > 0) begin
      ea = exp_q[0][2*W-1:W];
      eb = exp_q[0][W-1:0];
      check("a_reg", {16'd0, a_reg}, {16'd0, ea});
      check("b_reg", {16'd0, b_reg}, {16'd0, eb});
      check("a_sign", {31'd0, a_sign}, {31'd0, $signed(ea) < 0});
      check("b_sign", {31'd0, b_sign}, {31'd0, $signed(eb) < 0});
      check("zero_flag", {31'd0, zero_flag}, {31'd0, (ea == 0) || (eb == 0)});
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive, advance the model across the rising
  // edge, then optionally check at the next falling edge.
  task automatic cyc(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic ordy, input logic r, input bit chk);
    bit acc;
    bit hand;
    in_valid  = v;
    a_num     = a;
    b_num     = b;
    out_ready = ordy;
    rst       = r;
    acc  = v && (exp_q.size() < 2);
    hand = ordy && (exp_q.size() > 0);
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      exp_cnt = 16'd0;
    end else begin
      if (hand) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({a, b});
        exp_cnt = exp_cnt + 16'd1;
      end
    end
    @(negedge clk);
    if (chk) check_outputs();
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    exp_cnt   = 16'd0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a_num     = '0;
    b_num     = '0;
    out_ready = 1'b0;
    @(negedge clk);

    // Reset state, including a reset edge with in_valid high.
    cyc(1'b1, 16'h1234, 16'h5678, 1'b0, 1'b1, 1'b0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_a_reg", {16'd0, a_reg}, 32'd0);
    check("rst_b_reg", {16'd0, b_reg}, 32'd0);
    check("rst_signs", {30'd0, a_sign, b_sign}, 32'd0);
    check("rst_zero", {31'd0, zero_flag}, 32'd0);
    check("rst_op_cnt", {16'd0, op_cnt}, 32'd0);
    do_reset();

    // Single pair, latency one.
    cyc(1'b1, 16'h0003, 16'hFFFE, 1'b1, 1'b0, 1'b1);
    check("single_valid", {31'd0, out_valid}, 32'd1);
    check("single_a", {16'd0, a_reg}, 32'h0003);
    check("single_b", {16'd0, b_reg}, 32'hFFFE);
    check("single_signs", {30'd0, a_sign, b_sign}, 32'd1);
    check("single_zero", {31'd0, zero_flag}, 32'd0);
    check("single_cnt", {16'd0, op_cnt}, 32'd1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Backpressure: third pair must wait, then in-order drain.
    do_reset();
    cyc(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    cyc(1'b1, 16'h0005, 16'h0006, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'h0005, 16'h0006, 1'b0, 1'b0, 1'b1);
    check("bp_hold_a", {16'd0, a_reg}, 32'h0001);
    check("bp_cnt2", {16'd0, op_cnt}, 32'd2);
    cyc(1'b1, 16'h0005, 16'h0006, 1'b1, 1'b0, 1'b1);
    check("bp_second_a", {16'd0, a_reg}, 32'h0003);
    cyc(1'b1, 16'h0005, 16'h0006, 1'b1, 1'b0, 1'b1);
    check("bp_third_a", {16'd0, a_reg}, 32'h0005);
    check("bp_third_b", {16'd0, b_reg}, 32'h0006);
    check("bp_cnt3", {16'd0, op_cnt}, 32'd3);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Zero detection and most-negative operands.
    cyc(1'b1, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1);
    check("zero_flag_set", {31'd0, zero_flag}, 32'd1);
    check("zero_b_sign", {31'd0, b_sign}, 32'd1);
    cyc(1'b1, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1);
    check("minneg_zero", {31'd0, zero_flag}, 32'd0);
    check("minneg_signs", {30'd0, a_sign, b_sign}, 32'd3);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Streaming: one pair per cycle with no gaps.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, W'(i + 1), W'(i + 101), 1'b1, 1'b0, 1'b1);
      check("stream_state", {30'd0, dbg_state}, {30'd0, ST_ONE});
      check("stream_a", {16'd0, a_reg}, 32'(i + 1));
    end
    check("stream_cnt", {16'd0, op_cnt}, 32'd100);
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

    // Reset while FULL discards both entries.
    do_reset();
    cyc(1'b1, 16'h0011, 16'h0022, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'h0033, 16'h0044, 1'b0, 1'b0, 1'b1);
    check("mid_full_state", {30'd0, dbg_state}, {30'd0, ST_FULL});
    cyc(1'b1, 16'h0055, 16'h0066, 1'b1, 1'b1, 1'b1);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_cnt", {16'd0, op_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
      check("mid_no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Random traffic with biased corner operands.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 5))
        0: ra = '0;
        1: ra = 16'h8000;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 16'h8000;
        default: rb = W'($urandom);
      endcase
      cyc($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 2) != 0,
          $urandom_range(0, 199) == 0, 1'b1);
    end

    // Counter wrap after 65536 accepts.
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      cyc(1'b1, W'(i), W'(~i), 1'b1, 1'b0, 1'b0);
    end
    check_outputs();
    check("wrap_cnt", {16'd0, op_cnt}, 32'd0);
    cyc(1'b1, 16'h0007, 16'h0009, 1'b1, 1'b0, 1'b1);
    check("wrap_cnt_plus1", {16'd0, op_cnt}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
